// File: rtl/h_eqlz_seq.sv
// Per-RE channel coefficient sequencer for one NB-IoT subframe (14 symbols x 12 subcarriers); optional macro HEQ_PILOT_SKIP_EN skips divider requests on pilot symbols.
// Latency: REQ -> WAIT -> OUT, min 3 cycles per RE with a 1-cycle divider; load of N_SC pilot beats precedes the first request.
// Backpressure: h_valid holds the coefficient stable until h_ready; no new divider request is issued while an RE is unaccepted.
module h_eqlz_seq #(
  parameter int WIDTH = 16,
  parameter int N_SC  = 12,
  parameter int N_SYM = 14,
  parameter int P1    = 5,
  parameter int P2    = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             est_valid,
  input  logic [WIDTH-1:0] est1,
  input  logic [WIDTH-1:0] est2,
  output logic             div_start,
  output logic [3:0]       div_sym,
  output logic [3:0]       div_sc,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_res_1,
  input  logic [WIDTH-1:0] div_res_2,
  output logic [WIDTH-1:0] h_eqlz,
  output logic [1:0]       h_sel,
  output logic [3:0]       h_sym,
  output logic [3:0]       h_sc,
  output logic             h_valid,
  input  logic             h_ready,
  output logic             busy,
  output logic             frame_done
);

`ifdef HEQ_PILOT_SKIP_EN
  localparam logic SKIP = 1'b1;
`else
  localparam logic SKIP = 1'b0;
`endif

  localparam logic [3:0] P1_L     = 4'(P1);
  localparam logic [3:0] P2_L     = 4'(P2);
  localparam logic [3:0] SC_LAST  = 4'(N_SC - 1);
  localparam logic [3:0] SYM_LAST = 4'(N_SYM - 1);
  // symbols before the midpoint take the first-slot interpolation
  localparam logic [3:0] HALF     = 4'(N_SYM / 2);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, OUT} state_t;

  state_t           state;
  logic [WIDTH-1:0] buf1 [N_SC];
  logic [WIDTH-1:0] buf2 [N_SC];
  logic [3:0]       sym;
  logic [3:0]       sc;
  logic [3:0]       ld_cnt;

  logic             ld_we;
  logic             last_sc;
  logic             last_re;
  logic [3:0]       nsym;
  logic [3:0]       nsc;
  logic [WIDTH-1:0] pick_val;
  logic [1:0]       pick_sel;

  function automatic logic is_pilot(input logic [3:0] s);
    return (s == P1_L) || (s == P2_L);
  endfunction

  // load enable, next RE coordinates and coefficient selection for the current RE
  always_comb begin
    // the IDLE cycle that carries frame_done does not start a new load
    ld_we    = est_valid && (((state == IDLE) && !frame_done) || (state == LOAD));
    last_sc  = (sc == SC_LAST);
    last_re  = last_sc && (sym == SYM_LAST);
    nsc      = last_sc ? 4'd0 : sc + 4'd1;
    nsym     = last_sc ? sym + 4'd1 : sym;
    pick_val = div_res_2;
    pick_sel = 2'b00;
    if (sym == P1_L) begin
      pick_val = buf1[sc];
      pick_sel = 2'b01;
    end else if (sym == P2_L) begin
      pick_val = buf2[sc];
      pick_sel = 2'b11;
    end else if (sym < HALF) begin
      pick_val = div_res_1;
      pick_sel = 2'b10;
    end
  end

  // pilot estimate buffer, one entry per subcarrier; contents need no reset
  always_ff @(posedge CLK) begin
    if (ld_we) begin
      buf1[ld_cnt] <= est1;
      buf2[ld_cnt] <= est2;
    end
  end

  // sequencer FSM with registered handshake and coefficient outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      sym        <= 4'd0;
      sc         <= 4'd0;
      ld_cnt     <= 4'd0;
      div_start  <= 1'b0;
      div_sym    <= 4'd0;
      div_sc     <= 4'd0;
      h_eqlz     <= '0;
      h_sel      <= 2'b00;
      h_sym      <= 4'd0;
      h_sc       <= 4'd0;
      h_valid    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_we) begin
            ld_cnt <= 4'd1;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (ld_we) begin
            if (ld_cnt == SC_LAST) begin
              ld_cnt    <= 4'd0;
              sym       <= 4'd0;
              sc        <= 4'd0;
              div_start <= !(SKIP && is_pilot(4'd0));
              div_sym   <= 4'd0;
              div_sc    <= 4'd0;
              state     <= REQ;
            end else begin
              ld_cnt <= ld_cnt + 4'd1;
            end
          end
        end
        REQ: begin
          div_start <= 1'b0;
          if (SKIP && is_pilot(sym)) begin
            // pilot value is already buffered, no divider round trip needed
            h_eqlz  <= pick_val;
            h_sel   <= pick_sel;
            h_sym   <= sym;
            h_sc    <= sc;
            h_valid <= 1'b1;
            state   <= OUT;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (div_done) begin
            h_eqlz  <= pick_val;
            h_sel   <= pick_sel;
            h_sym   <= sym;
            h_sc    <= sc;
            h_valid <= 1'b1;
            state   <= OUT;
          end
        end
        OUT: begin
          if (h_ready) begin
            h_valid <= 1'b0;
            if (last_re) begin
              sym        <= 4'd0;
              sc         <= 4'd0;
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              sym       <= nsym;
              sc        <= nsc;
              div_start <= !(SKIP && is_pilot(nsym));
              div_sym   <= nsym;
              div_sc    <= nsc;
              state     <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h_eqlz_seq.sv
module tb_h_eqlz_seq;

`ifdef HEQ_PILOT_SKIP_EN
  localparam bit SKIP    = 1'b1;
  localparam int EXP_REQ = 144;
`else
  localparam bit SKIP    = 1'b0;
  localparam int EXP_REQ = 168;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        est_valid;
  logic [15:0] est1, est2;
  logic        div_start;
  logic [3:0]  div_sym, div_sc;
  logic        div_done;
  logic [15:0] div_res_1, div_res_2;
  logic [15:0] h_eqlz;
  logic [1:0]  h_sel;
  logic [3:0]  h_sym, h_sc;
  logic        h_valid;
  logic        h_ready;
  logic        busy;
  logic        frame_done;

  h_eqlz_seq #(.WIDTH(16), .N_SC(12), .N_SYM(14), .P1(5), .P2(12)) dut (
    .CLK(CLK), .RST(RST), .est_valid(est_valid), .est1(est1), .est2(est2),
    .div_start(div_start), .div_sym(div_sym), .div_sc(div_sc),
    .div_done(div_done), .div_res_1(div_res_1), .div_res_2(div_res_2),
    .h_eqlz(h_eqlz), .h_sel(h_sel), .h_sym(h_sym), .h_sc(h_sc),
    .h_valid(h_valid), .h_ready(h_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int stall_s = -1, stall_c = -1;
  bit spur = 1'b0;
  int dcnt = 0;
  int nstart = 0;
  int fd_cnt = 0;
  logic [3:0]  rq_sym = 4'd0, rq_sc = 4'd0;
  logic [17:0] cap [14][12];

  typedef struct {
    int          sym;
    int          sc;
    logic [15:0] val;
    logic [1:0]  sel;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // reference selection rule: {h_sel, h_eqlz} for an RE of the standard frame
  function automatic logic [17:0] model(input int s, input int c);
    if (s == 5)  return {2'b01, 16'(16'h0100 + c)};
    if (s == 12) return {2'b11, 16'(16'h0200 + c)};
    if (s < 7)   return {2'b10, 16'h1000};
    return {2'b00, 16'h2000};
  endfunction

  // divider model: 1-cycle latency, 10 cycles for the stall RE, optional spurious pulse
  initial begin
    div_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (dcnt > 0) begin
        dcnt--;
        div_done = (dcnt == 0);
      end else begin
        div_done = 1'b0;
      end
      if (spur) begin
        div_done = 1'b1;
        spur = 1'b0;
      end
      if (div_start === 1'b1) begin
        nstart++;
        rq_sym = div_sym;
        rq_sc  = div_sc;
        dcnt = (int'(div_sym) == stall_s && int'(div_sc) == stall_c) ? 10 : 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic load_frame();
    for (int k = 0; k < 12; k++) begin
      est_valid = 1'b1;
      est1 = 16'(16'h0100 + k);
      est2 = 16'(16'h0200 + k);
      @(negedge CLK);
    end
    est_valid = 1'b0;
    chk("load_to_req", {div_start, div_sym, div_sc, busy}, {1'b1, 8'h00, 1'b1});
  endtask

  task automatic run_frame(input int bp_s, input int bp_c, input int ab_s, input int ab_c,
                           output bit aborted);
    int n;
    logic [25:0] snap;
    aborted = 1'b0;
    for (int s = 0; s < 14; s++) begin
      for (int c = 0; c < 12; c++) begin
        n = 0;
        while (h_valid !== 1'b1 && n < 40) begin
          @(negedge CLK);
          n++;
        end
        if (h_valid !== 1'b1) begin
          chk("re_timeout", 64'(h_valid), 64'd1);
          aborted = 1'b1;
          return;
        end
        chk("re", {h_sym, h_sc, h_sel, h_eqlz}, {4'(s), 4'(c), model(s, c)});
        if (!(SKIP && (s == 5 || s == 12)))
          chk("div_req", {rq_sym, rq_sc}, {4'(s), 4'(c)});
        cap[s][c] = {h_sel, h_eqlz};
        if (s == 0 && c == 1) chk("re_period", 64'(n), 64'd2);
        if (s == ab_s && c == ab_c) begin
          RST = 1'b1;
          #1;
          chk("abort_out", {div_start, div_sym, div_sc, h_eqlz, h_sel, h_sym, h_sc,
                            h_valid, busy, frame_done}, 64'd0);
          @(negedge CLK);
          RST = 1'b0;
          aborted = 1'b1;
          return;
        end
        if (s == bp_s && c == bp_c) begin
          snap = {h_eqlz, h_sel, h_sym, h_sc};
          h_ready = 1'b0;
          repeat (5) begin
            @(negedge CLK);
            chk("bp_hold", {h_valid, div_start, h_eqlz, h_sel, h_sym, h_sc}, {2'b10, snap});
          end
          h_ready = 1'b1;
        end
        if (s == stall_s && c == stall_c) begin
          chk("stall_wait", 64'(n), 64'd11);
          snap = {h_eqlz, h_sel, h_sym, h_sc};
          h_ready = 1'b0;
          div_res_1 = 16'hBEEF;
          spur = 1'b1;
          repeat (3) @(negedge CLK);
          chk("spur_hold", {h_valid, h_eqlz, h_sel, h_sym, h_sc}, {1'b1, snap});
          div_res_1 = 16'h1000;
          h_ready = 1'b1;
        end
        @(negedge CLK);
        if (s == bp_s && c == bp_c) chk("valid_fall", 64'(h_valid), 64'd0);
      end
    end
    chk("frame_end", {frame_done, busy, h_valid}, 3'b100);
  endtask

  initial begin
    bit ab;
    tbl[0]  = '{0,  0,  16'h1000, 2'b10};
    tbl[1]  = '{4,  11, 16'h1000, 2'b10};
    tbl[2]  = '{5,  0,  16'h0100, 2'b01};
    tbl[3]  = '{5,  11, 16'h010B, 2'b01};
    tbl[4]  = '{6,  3,  16'h1000, 2'b10};
    tbl[5]  = '{7,  0,  16'h2000, 2'b00};
    tbl[6]  = '{12, 0,  16'h0200, 2'b11};
    tbl[7]  = '{12, 7,  16'h0207, 2'b11};
    tbl[8]  = '{13, 11, 16'h2000, 2'b00};
    tbl[9]  = '{11, 5,  16'h2000, 2'b00};
    tbl[10] = '{3,  7,  16'h1000, 2'b10};
    tbl[11] = '{9,  4,  16'h2000, 2'b00};

    RST = 1'b1; est_valid = 1'b0; est1 = '0; est2 = '0;
    div_res_1 = 16'h1000; div_res_2 = 16'h2000; h_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_out", {div_start, div_sym, div_sc, h_eqlz, h_sel, h_sym, h_sc,
                      h_valid, busy, frame_done}, 64'd0);
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("idle", {busy, div_start, h_valid, frame_done}, 4'b0000);

    // frame 1: plain full frame
    nstart = 0;
    load_frame();
    run_frame(-1, -1, -1, -1, ab);
    est_valid = 1'b1; est1 = 16'hEEEE; est2 = 16'hEEEE;
    @(negedge CLK);
    est_valid = 1'b0;
    chk("no_load_on_done", 64'(busy), 64'd0);
    chk("fd_cnt1", 64'(fd_cnt), 64'd1);
    chk("div_starts1", 64'(nstart), 64'(EXP_REQ));
    for (int i = 0; i < 12; i++)
      chk("tbl", {4'(tbl[i].sym), 4'(tbl[i].sc), cap[tbl[i].sym][tbl[i].sc]},
                 {4'(tbl[i].sym), 4'(tbl[i].sc), tbl[i].sel, tbl[i].val});

    // frame 2: divider stall with spurious done at (2,3), backpressure at (3,7)
    stall_s = 2; stall_c = 3;
    nstart = 0;
    load_frame();
    run_frame(3, 7, -1, -1, ab);
    @(negedge CLK);
    chk("fd_cnt2", 64'(fd_cnt), 64'd2);
    chk("div_starts2", 64'(nstart), 64'(EXP_REQ));
    stall_s = -1; stall_c = -1;

    // frame 3: reset at RE (9,4)
    load_frame();
    run_frame(-1, -1, 9, 4, ab);
    chk("aborted", 64'(ab), 64'd1);
    repeat (3) @(negedge CLK);
    chk("abort_no_done", {32'(fd_cnt), 1'(busy)}, {32'd2, 1'b0});

    // frame 4: clean frame after the abort
    nstart = 0;
    load_frame();
    run_frame(-1, -1, -1, -1, ab);
    @(negedge CLK);
    chk("fd_cnt4", 64'(fd_cnt), 64'd3);
    chk("div_starts4", 64'(nstart), 64'(EXP_REQ));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
